outputc: RTL

//  Output-channel controller for one physical output port of the router; sits downstream of the

---
 rtl/outputc.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/outputc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : outputc                                                      |
// | Description : Router output-channel controller. Registers the switched     |
// |               flit onto the link, tracks per-VC downstream credits and a   |
// |               per-VC wormhole lock. Optional protocol-error checking is    |
// |               enabled by defining OUTPUTC_ERRCHK_EN.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module outputc #(
  parameter int ROUTERID  = 0,
  parameter int PCHID     = 0,
  parameter int BUF_DEPTH = 4,
  parameter int CNTW      = 3,
  parameter int DATAW     = 15,
  parameter int VCH       = 1,
  parameter int VCHW      = 1,
  parameter int TYPE_MSB  = DATAW,
  parameter int TYPE_LSB  = DATAW - 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DATAW:0]   idata,
  input  logic             ivalid,
  input  logic [VCHW:0]    ivch,
  input  logic [VCH:0]     iack,
  output logic [DATAW:0]   odata,
  output logic             ovalid,
  output logic [VCHW:0]    ovch,
  output logic [VCH:0]     ordy,
  output logic [VCH:0]     olck,
  output logic             err
);

  localparam int c_tw = TYPE_MSB - TYPE_LSB + 1;

  localparam logic [c_tw-1:0] c_type_none     = c_tw'(0);
  localparam logic [c_tw-1:0] c_type_head     = c_tw'(1);
  localparam logic [c_tw-1:0] c_type_body     = c_tw'(2);
  localparam logic [c_tw-1:0] c_type_tail     = c_tw'(3);
  localparam logic [c_tw-1:0] c_type_headtail = c_tw'(4);

  localparam logic [CNTW:0] c_full = (CNTW+1)'(BUF_DEPTH);
  localparam logic [CNTW:0] c_one  = (CNTW+1)'(1);

  typedef enum logic [0:0] {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  logic [c_tw-1:0] w_type;
  logic            w_vch_ok;
  logic            w_accept;
  logic            w_unused_ids;

  // Identifiers only serve diagnostics; keep them referenced for lint.
  assign w_unused_ids = ^{32'(ROUTERID), 32'(PCHID)};

  assign w_type   = idata[TYPE_MSB:TYPE_LSB];
  assign w_vch_ok = (32'(ivch) <= 32'(VCH));
  assign w_accept = ivalid && (w_type != c_type_none) && w_vch_ok;

`ifdef OUTPUTC_ERRCHK_EN
  logic [VCH:0] w_err_vc;
`endif

  // Link register: accepted flit goes out next cycle, otherwise the link is zeroed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      odata  <= '0;
      ovalid <= 1'b0;
      ovch   <= '0;
    end else begin
      odata  <= w_accept ? idata : '0;
      ovalid <= w_accept;
      ovch   <= w_accept ? ivch : '0;
    end
  end

  for (genvar v = 0; v <= VCH; v++) begin : g_vc
    logic          w_send;
    logic [CNTW:0] r_credit;
    logic [CNTW:0] w_credit_next;
    lock_state_t   r_lock;
    lock_state_t   w_lock_next;

    assign w_send = w_accept && (32'(ivch) == 32'(v));

    // Credit update: send and return in one cycle cancel; both ends saturate.
    always_comb begin
      w_credit_next = r_credit;
      if (w_send && !iack[v]) begin
        if (r_credit != '0) w_credit_next = r_credit - c_one;
      end else if (!w_send && iack[v]) begin
        if (r_credit != c_full) w_credit_next = r_credit + c_one;
      end
    end

    // Credit register, reset to the downstream FIFO depth.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_credit <= c_full;
      else     r_credit <= w_credit_next;
    end

    // Lock state register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_lock <= FREE;
      else     r_lock <= w_lock_next;
    end

    // Wormhole lock next-state: head opens the VC, tail closes it.
    always_comb begin
      w_lock_next = r_lock;
      if (w_send) begin
        case (r_lock)
          FREE:    if (w_type == c_type_head) w_lock_next = LOCKED;
          LOCKED:  if (w_type == c_type_tail) w_lock_next = FREE;
          default: w_lock_next = FREE;
        endcase
      end
    end

    assign ordy[v] = (r_credit != '0);
    assign olck[v] = (r_lock == LOCKED);

`ifdef OUTPUTC_ERRCHK_EN
    assign w_err_vc[v] =
        (w_send && !iack[v] && (r_credit == '0)) ||
        (!w_send && iack[v] && (r_credit == c_full)) ||
        (w_send && (r_lock == FREE) &&
         ((w_type == c_type_body) || (w_type == c_type_tail))) ||
        (w_send && (r_lock == LOCKED) &&
         ((w_type == c_type_head) || (w_type == c_type_headtail)));
`endif
  end

`ifdef OUTPUTC_ERRCHK_EN
  logic r_err;

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= r_err | (|w_err_vc);
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire
